// File: rtl/symbol_sink.sv
// symbol_sink: packs 2-bit symbols LSB-first into words and queues them in a show-ahead FIFO (optional SINK_PARITY_EN adds out_par)
module symbol_sink #(
  parameter int SYMS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sym,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*SYMS-1:0]   out_word,
  output logic [4:0]          word_cnt
`ifdef SINK_PARITY_EN
  ,
  output logic                out_par
`endif
);
  localparam int W  = 2 * SYMS;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state;
  logic [3:0] idx, idx_nxt;
  logic [W-1:0] asm_q, asm_nxt, ins;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic accept, push, pop, last;
  assign in_ready  = (word_cnt != 5'(DEPTH)) & ~flush;
  assign out_valid = word_cnt != 5'd0;
  assign out_word  = mem[rp];
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign last      = idx == 4'(SYMS - 1);
  // Next assembly state: insert the accepted symbol at slot idx, complete the word on the last slot
  always_comb begin
    state = (idx == 4'd0) ? IDLE : FILL;
    ins = asm_q;
    ins[2*idx +: 2] = in_sym;
    push = accept & (state == FILL) & last;
    idx_nxt = flush ? 4'd0 : push ? 4'd0 : accept ? idx + 4'd1 : idx;
    asm_nxt = (flush | push) ? '0 : accept ? ins : asm_q;
  end
  // Assembly register and symbol index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= 4'd0;
      asm_q <= '0;
    end else begin
      idx   <= idx_nxt;
      asm_q <= asm_nxt;
    end
  end
  // Word FIFO: storage, wrapping pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      word_cnt <= 5'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= ins;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      word_cnt <= word_cnt + 5'(push) - 5'(pop);
    end
  end
`ifdef SINK_PARITY_EN
  logic par_mem [DEPTH];
  assign out_par = par_mem[rp];
  // Per-entry parity stored alongside each queued word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
    end else if (push) begin
      par_mem[wp] <= ^ins;
    end
  end
`endif
endmodule

// File: tb/tb_symbol_sink.sv
// tb_symbol_sink: directed table-driven and sequence checks for symbol_sink
module tb_symbol_sink;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [1:0] in_sym = 0;
  logic [7:0] out_word;
  logic [4:0] word_cnt;
  int checks = 0, errors = 0;
`ifdef SINK_PARITY_EN
  logic out_par;
`endif

  symbol_sink #(.SYMS(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .word_cnt(word_cnt)
`ifdef SINK_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [1:0] s; logic f; logic r;
    logic er; logic ev; logic cw; logic [7:0] ew; logic [4:0] ec;
  } vec_t;
  vec_t tbl[$];
  logic [7:0] exp_w [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] s);
    int n = 0;
    in_valid = 1;
    in_sym = s;
    #1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    step();
    in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_w = '{8'hE4, 8'h39, 8'h4E, 8'h93, 8'hE4};
    tbl.push_back('{1, 1, 0, 1, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 2, 0, 1, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 3, 0, 1, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 1, 8'h39, 1});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 3, 0, 0, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 3, 0, 0, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{1, 2, 1, 0, 0, 0, 0, 8'h00, 0});
    for (int i = 0; i < 4; i++) tbl.push_back('{1, 1, 0, 0, 1, 0, 0, 8'h00, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 1, 8'h55, 1});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 1, 8'h55, 1});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 8'h00, 0});

    #1;
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_word", 32'(out_word), 0);
    chk("reset_word_cnt", 32'(word_cnt), 0);
    step();
    step();
    rst = 0;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v;
      in_sym = tbl[i].s;
      flush = tbl[i].f;
      out_ready = tbl[i].r;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].er));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_word_cnt", i), 32'(word_cnt), 32'(tbl[i].ec));
      if (tbl[i].cw) chk($sformatf("vec%0d_out_word", i), 32'(out_word), 32'(tbl[i].ew));
      step();
    end
    in_valid = 0;
    flush = 0;
    out_ready = 0;

`ifdef SINK_PARITY_EN
    send(1); send(2); send(3); send(0);
    chk("par_39_word", 32'(out_word), 32'h39);
    chk("par_39", 32'(out_par), 0);
    out_ready = 1;
    step();
    out_ready = 0;
    send(1); send(0); send(0); send(0);
    chk("par_01_word", 32'(out_word), 32'h01);
    chk("par_01", 32'(out_par), 1);
    out_ready = 1;
    step();
    out_ready = 0;
`endif

    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) send(2'((k + j) % 4));
    chk("full_word_cnt", 32'(word_cnt), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_head", 32'(out_word), 32'(exp_w[0]));
    in_valid = 1;
    in_sym = 0;
    step(); step(); step();
    chk("stall_word_cnt", 32'(word_cnt), 4);
    chk("stall_in_ready", 32'(in_ready), 0);
    out_ready = 1;
    #1;
    chk("pop0_word", 32'(out_word), 32'(exp_w[0]));
    step();
    out_ready = 0;
    chk("after_pop_in_ready", 32'(in_ready), 1);
    chk("after_pop_word_cnt", 32'(word_cnt), 3);
    step();
    in_valid = 0;
    send(1); send(2); send(3);
    chk("refill_word_cnt", 32'(word_cnt), 4);
    chk("refill_in_ready", 32'(in_ready), 0);

    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_word", i), 32'(out_word), 32'(exp_w[i+1]));
      step();
      chk($sformatf("drain%0d_cnt", i), 32'(word_cnt), 32'(3 - i));
    end
    out_ready = 0;
    chk("drained_out_valid", 32'(out_valid), 0);

    send(1); send(1); send(1); send(1);
    send(2); send(2);
    chk("pre_rst_word_cnt", 32'(word_cnt), 1);
    rst = 1;
    #1;
    chk("rst_async_out_valid", 32'(out_valid), 0);
    step();
    rst = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_word", 32'(out_word), 0);
    send(1); send(2); send(3); send(0);
    chk("post_rst_out_valid", 32'(out_valid), 1);
    chk("post_rst_word", 32'(out_word), 32'h39);
    chk("post_rst_word_cnt", 32'(word_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
